// File: rtl/maze_frame_renderer.sv
// Walks the LT24 frame pixel by pixel. Each 8x8 tile maps to one maze cell bit, and the
// resulting RGB565 value is written through the LT24Display pixel handshake.
module maze_frame_renderer #(
    parameter int unsigned WIDTH          = 240,
    parameter int unsigned HEIGHT         = 320,
    parameter int unsigned MAZE_W         = 30,
    parameter int unsigned MAZE_H         = 10,
    parameter logic [15:0] WALL_COLOUR    = 16'h0000,
    parameter logic [15:0] FLOOR_COLOUR   = 16'h07E0,
    parameter logic [15:0] PLAYER_COLOUR  = 16'hF800,
    parameter logic [15:0] OUTSIDE_COLOUR = 16'h001F
) (
    input  logic        clock,
    input  logic        resetApp,
    input  logic        frameStart,
    input  logic        mazeReady,
    output logic [10:0] cellAddr,
    input  logic        cellData,
    input  logic [4:0]  playerX,
    input  logic [3:0]  playerY,
    output logic [7:0]  xAddr,
    output logic [8:0]  yAddr,
    output logic [15:0] pixelData,
    output logic        pixelWrite,
    input  logic        pixelReady,
    output logic        busy,
    output logic        frameDone
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StWrite,
        StAdvance
    } state_e;

    localparam logic [7:0]  XLast     = 8'(WIDTH - 1);
    localparam logic [8:0]  YLast     = 9'(HEIGHT - 1);
    localparam logic [8:0]  MazeRows  = 9'(MAZE_H * 8);
    localparam logic [10:0] RowStride = 11'(MAZE_W);
    localparam logic [4:0]  TileCols  = 5'(MAZE_W);
    localparam logic [3:0]  TileRows  = 4'(MAZE_H);

    state_e      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [10:0] cell_addr_q, cell_addr_d;
    logic [15:0] pixel_q, pixel_d;
    logic [4:0]  player_x_q, player_x_d;
    logic [3:0]  player_y_q, player_y_d;
    logic        frame_done_q, frame_done_d;

    logic [10:0] tile_addr;
    logic        in_maze;
    logic        player_valid;
    logic        player_hit;
    logic        last_pixel;

    assign tile_addr    = {6'd0, x_q[7:3]} + RowStride * {5'd0, y_q[8:3]};
    assign in_maze      = (y_q < MazeRows);
    // Out-of-range player coordinates must never light a tile.
    assign player_valid = (player_x_q < TileCols) && (player_y_q < TileRows);
    assign player_hit   = in_maze && player_valid && (x_q[7:3] == player_x_q) &&
                          (y_q[8:3] == {2'b00, player_y_q});
    assign last_pixel   = (x_q == XLast) && (y_q == YLast);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        cell_addr_d  = cell_addr_q;
        pixel_d      = pixel_q;
        player_x_d   = player_x_q;
        player_y_d   = player_y_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frameStart && mazeReady) begin
                    player_x_d = playerX;
                    player_y_d = playerY;
                    x_d        = 8'd0;
                    y_d        = 9'd0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                // Below the maze the address freezes so the cell port stays quiet.
                if (in_maze) begin
                    cell_addr_d = tile_addr;
                end
                state_d = StWait;
            end
            StWait: begin
                if (player_hit) begin
                    pixel_d = PLAYER_COLOUR;
                end else if (in_maze && cellData) begin
                    pixel_d = WALL_COLOUR;
                end else if (in_maze) begin
                    pixel_d = FLOOR_COLOUR;
                end else begin
                    pixel_d = OUTSIDE_COLOUR;
                end
                state_d = StWrite;
            end
            StWrite: begin
                if (pixelReady) begin
                    frame_done_d = last_pixel;
                    state_d      = StAdvance;
                end
            end
            StAdvance: begin
                if (last_pixel) begin
                    x_d     = 8'd0;
                    y_d     = 9'd0;
                    state_d = StIdle;
                end else begin
                    if (x_q < XLast) begin
                        x_d = x_q + 8'd1;
                    end else begin
                        x_d = 8'd0;
                        y_d = y_q + 9'd1;
                    end
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q      <= StIdle;
            x_q          <= 8'd0;
            y_q          <= 9'd0;
            cell_addr_q  <= 11'd0;
            pixel_q      <= 16'd0;
            player_x_q   <= 5'd0;
            player_y_q   <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cell_addr_q  <= cell_addr_d;
            pixel_q      <= pixel_d;
            player_x_q   <= player_x_d;
            player_y_q   <= player_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cellAddr   = cell_addr_q;
    assign xAddr      = x_q;
    assign yAddr      = y_q;
    assign pixelData  = pixel_q;
    assign pixelWrite = (state_q == StWrite);
    assign busy       = (state_q != StIdle);
    assign frameDone  = frame_done_q;

endmodule
